int_alu_dispatch: RTL and testbench
===================================

INT_ALU_DISPATCH -- requirements
Module: int_alu_dispatch

Interface
REQ-001 Parameter TAG_W, default 4: width of the issue/writeback tag.
REQ-002 Data width SHALL be INT_DATA_W from general_defines.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 iss_valid  in  1  issue request.
REQ-006 iss_op  in  2  opcode: 0=ADD, 1=SUB, 2=MUL, 3=DIV.
REQ-007 iss_a, iss_b  in  INT_DATA_W each  operands.
REQ-008 iss_tag  in  TAG_W  destination tag.
REQ-009 iss_ready  out  1  op accepted on an edge where iss_valid && iss_ready.
REQ-010 {add,sub,mul,div}_valid  out  1 each  one-cycle start pulse to the unit.
REQ-011 {add,sub,mul,div}_a, _b  out  INT_DATA_W each  registered operands to the unit.
REQ-012 {add,sub,mul,div}_result  in  INT_DATA_W each  unit result.
REQ-013 add_done, sub_done  in  1 each  adder/subtractor valid_o.
REQ-014 mul_busy, div_busy  in  1 each  multiplier/divider busy.
REQ-015 wb_valid  out  1  result present this cycle; no backpressure.
REQ-016 wb_op  out  2; wb_tag  out  TAG_W; wb_data  out  INT_DATA_W.
REQ-017 idle  out  1  no op in flight and no result pending.

Function
REQ-018 Per unit u, state: inflight_u, tag_u, slot_pend_u, slot_data_u, slot_tag_u.
REQ-019 iss_ready SHALL be combinational on iss_op: high iff rst high && !inflight_u && !slot_pend_u, plus !mul_busy for MUL and !div_busy for DIV.
REQ-020 On accept at edge E: u_valid=1 and u_a/u_b=iss_a/iss_b during cycle [E,E+1); inflight_u=1; tag_u=iss_tag.
REQ-021 u_valid SHALL drop after one cycle; u_a/u_b SHALL hold until the next accept for that unit.
REQ-022 ADD/SUB completion: u_done high while inflight_u -> at next edge slot_pend_u=1, slot_data_u=u_result, slot_tag_u=tag_u, inflight_u=0.
REQ-023 MUL/DIV completion: registered busy_q; falling edge (busy_q && !busy) while inflight_u -> capture as REQ-022 at next edge.
REQ-024 Done/busy events with inflight_u=0 SHALL be ignored.
REQ-025 Latency, accept edge E to wb_valid cycle: ADD/SUB [E+2,E+3); MUL [E+6,E+7); DIV [E+10,E+11); each when uncontested.
REQ-026 wb_* SHALL be combinational from the highest-priority pending slot: DIV > MUL > SUB > ADD; wb_valid=0 and wb_tag/wb_data/wb_op=0 when none pending.
REQ-027 The selected slot SHALL clear at the next edge; unselected slots hold; exactly one result per cycle.
REQ-028 Issue SHALL be allowed in the same cycle as a writeback of a different unit; a unit is not reissuable until its slot has cleared.
REQ-029 DIV with divisor 0 SHALL complete normally with wb_data = unit result (0).
REQ-030 idle = no inflight_u and no slot_pend_u.

Reset
REQ-031 rst low at an edge: all inflight_u, slot_pend_u, busy_q, u_valid, u_a/u_b, tags cleared to 0.
REQ-032 During and after reset: iss_ready=0 while rst low; wb_valid=0; idle=1 after first reset edge.
REQ-033 Ops in flight at reset SHALL be discarded; their later unit completions SHALL be ignored (REQ-024); MUL/DIV stay blocked by busy until the unit drains.

Verification
REQ-034 ADD a=5,b=7,tag=3 at E -> wb_valid only in [E+2,E+3), wb_op=0, wb_tag=3, wb_data=12.
REQ-035 MUL 6x7 tag=1 at E, then ADD 1+1 tag=2 at E+1 -> ADD wb (2) in [E+3,E+4); MUL wb (42) in [E+6,E+7); MUL iss_ready=0 from E until its slot clears.
REQ-036 DIV 100/0 tag=5 -> wb_data=0, tag=5, in [E+10,E+11).
REQ-037 MUL at E, DIV at E+4, forced simultaneous capture with SUB slot pending -> DIV, MUL, SUB written back on consecutive cycles, no result lost or duplicated.
REQ-038 DIV accepted, rst low at E+3 for one cycle -> no wb for that tag; DIV iss_ready=0 until div_busy falls; new DIV 9/3 then returns 3.
REQ-039 SUB 3-5 -> wb_data=2^INT_DATA_W-2 (wrap-around); second SUB with iss_valid held -> accepted only after first slot clears.

Source files
------------

// File: rtl/int_alu_dispatch.sv
// int_alu_dispatch
//   Issues integer ops to four external execution units (ADD, SUB, MUL, DIV).
//   Each unit takes one op at a time. Its result is parked in a per-unit slot
//   and written back on a single shared port in the priority DIV > MUL > SUB > ADD.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   iss_valid/op/a/b/tag  issue request; iss_ready is combinational on iss_op
//   <u>_valid, <u>_a/_b   one-cycle start pulse and held operands per unit
//   <u>_result            unit result
//   add_done, sub_done    ADD/SUB completion strobes
//   mul_busy, div_busy    MUL/DIV busy; completion is the busy falling edge
//   wb_valid/op/tag/data  writeback, no backpressure
//   idle                  nothing in flight and no result pending

package general_defines;
  localparam int unsigned INT_DATA_W = 32;
endpackage

module int_alu_dispatch
  import general_defines::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [1:0]            iss_op,
  input  logic [INT_DATA_W-1:0] iss_a,
  input  logic [INT_DATA_W-1:0] iss_b,
  input  logic [TAG_W-1:0]      iss_tag,
  output logic                  iss_ready,
  output logic                  add_valid,
  output logic [INT_DATA_W-1:0] add_a,
  output logic [INT_DATA_W-1:0] add_b,
  input  logic [INT_DATA_W-1:0] add_result,
  input  logic                  add_done,
  output logic                  sub_valid,
  output logic [INT_DATA_W-1:0] sub_a,
  output logic [INT_DATA_W-1:0] sub_b,
  input  logic [INT_DATA_W-1:0] sub_result,
  input  logic                  sub_done,
  output logic                  mul_valid,
  output logic [INT_DATA_W-1:0] mul_a,
  output logic [INT_DATA_W-1:0] mul_b,
  input  logic [INT_DATA_W-1:0] mul_result,
  input  logic                  mul_busy,
  output logic                  div_valid,
  output logic [INT_DATA_W-1:0] div_a,
  output logic [INT_DATA_W-1:0] div_b,
  input  logic [INT_DATA_W-1:0] div_result,
  input  logic                  div_busy,
  output logic                  wb_valid,
  output logic [1:0]            wb_op,
  output logic [TAG_W-1:0]      wb_tag,
  output logic [INT_DATA_W-1:0] wb_data,
  output logic                  idle
);

  localparam int unsigned N_UNITS = 4;

  // Unit index equals opcode; a higher index means higher writeback priority.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  logic [N_UNITS-1:0]    inflight;
  logic [N_UNITS-1:0]    slot_pend;
  logic [N_UNITS-1:0]    unit_valid;
  logic [N_UNITS-1:0]    unit_free;
  logic [N_UNITS-1:0]    done_evt;
  logic [N_UNITS-1:0]    accept_vec;
  logic [N_UNITS-1:0]    sel_vec;
  logic [1:0]            busy_q;      // [0] mul, [1] div
  logic [TAG_W-1:0]      tag_q      [N_UNITS];
  logic [TAG_W-1:0]      slot_tag   [N_UNITS];
  logic [INT_DATA_W-1:0] slot_data  [N_UNITS];
  logic [INT_DATA_W-1:0] op_a       [N_UNITS];
  logic [INT_DATA_W-1:0] op_b       [N_UNITS];
  logic [INT_DATA_W-1:0] unit_result[N_UNITS];

  always_comb begin
    unit_result[OP_ADD] = add_result;
    unit_result[OP_SUB] = sub_result;
    unit_result[OP_MUL] = mul_result;
    unit_result[OP_DIV] = div_result;
  end

  // Completion events only count while an op is outstanding on that unit, so
  // strobes from ops discarded by reset fall through harmlessly.
  assign done_evt  = inflight & {busy_q[1] & ~div_busy, busy_q[0] & ~mul_busy,
                                 sub_done, add_done};
  assign unit_free = ~inflight & ~slot_pend & {~div_busy, ~mul_busy, 2'b11};
  assign iss_ready = rst & unit_free[iss_op];
  assign idle      = ~|{inflight, slot_pend};

  always_comb begin
    accept_vec         = '0;
    accept_vec[iss_op] = iss_valid & iss_ready;
  end

  // Ascending scan: the last pending slot seen (highest index) wins.
  always_comb begin
    wb_valid = 1'b0;
    wb_op    = '0;
    wb_tag   = '0;
    wb_data  = '0;
    if (rst) begin
      for (int unsigned u = 0; u < N_UNITS; u++) begin
        if (slot_pend[u]) begin
          wb_valid = 1'b1;
          wb_op    = 2'(u);
          wb_tag   = slot_tag[u];
          wb_data  = slot_data[u];
        end
      end
    end
  end

  always_comb begin
    sel_vec = '0;
    if (wb_valid) sel_vec[wb_op] = 1'b1;
  end

  // Accept needs !inflight && !slot_pend, capture needs inflight and the
  // slot is cleared only while pending, so the three branches are exclusive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight   <= '0;
      slot_pend  <= '0;
      unit_valid <= '0;
      busy_q     <= '0;
      for (int unsigned u = 0; u < N_UNITS; u++) begin
        tag_q[u]     <= '0;
        slot_tag[u]  <= '0;
        slot_data[u] <= '0;
        op_a[u]      <= '0;
        op_b[u]      <= '0;
      end
    end else begin
      unit_valid <= accept_vec;
      busy_q     <= {div_busy, mul_busy};
      for (int unsigned u = 0; u < N_UNITS; u++) begin
        if (accept_vec[u]) begin
          inflight[u] <= 1'b1;
          tag_q[u]    <= iss_tag;
          op_a[u]     <= iss_a;
          op_b[u]     <= iss_b;
        end else if (done_evt[u]) begin
          inflight[u]  <= 1'b0;
          slot_pend[u] <= 1'b1;
          slot_data[u] <= unit_result[u];
          slot_tag[u]  <= tag_q[u];
        end else if (sel_vec[u]) begin
          slot_pend[u] <= 1'b0;
        end
      end
    end
  end

  assign add_valid = unit_valid[OP_ADD];
  assign add_a     = op_a[OP_ADD];
  assign add_b     = op_b[OP_ADD];
  assign sub_valid = unit_valid[OP_SUB];
  assign sub_a     = op_a[OP_SUB];
  assign sub_b     = op_b[OP_SUB];
  assign mul_valid = unit_valid[OP_MUL];
  assign mul_a     = op_a[OP_MUL];
  assign mul_b     = op_b[OP_MUL];
  assign div_valid = unit_valid[OP_DIV];
  assign div_a     = op_a[OP_DIV];
  assign div_b     = op_b[OP_DIV];

endmodule

// File: tb/tb_int_alu_dispatch.sv
// tb_int_alu_dispatch
//   Drives int_alu_dispatch with directed and random issue traffic. Behavioural
//   execution units are attached, and every cycle is compared against a
//   scheduling model: each accepted op gets a ready cycle, and writeback picks
//   the highest-priority ready op.

module tb_int_alu_dispatch;
  import general_defines::*;

  localparam int unsigned W     = INT_DATA_W;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             iss_valid;
  logic [1:0]       iss_op;
  logic [W-1:0]     iss_a, iss_b;
  logic [TAG_W-1:0] iss_tag;
  logic             iss_ready;
  logic             add_valid, sub_valid, mul_valid, div_valid;
  logic [W-1:0]     add_a, add_b, sub_a, sub_b, mul_a, mul_b, div_a, div_b;
  logic [W-1:0]     add_result = '0, sub_result = '0, mul_result = '0, div_result = '0;
  logic             add_done = 1'b0, sub_done = 1'b0, mul_busy = 1'b0, div_busy = 1'b0;
  logic             wb_valid;
  logic [1:0]       wb_op;
  logic [TAG_W-1:0] wb_tag;
  logic [W-1:0]     wb_data;
  logic             idle;

  always #5 clk = ~clk;

  int_alu_dispatch #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b),
    .iss_tag(iss_tag), .iss_ready(iss_ready),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_done(add_done),
    .sub_valid(sub_valid), .sub_a(sub_a), .sub_b(sub_b),
    .sub_result(sub_result), .sub_done(sub_done),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_busy(mul_busy),
    .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_busy(div_busy),
    .wb_valid(wb_valid), .wb_op(wb_op), .wb_tag(wb_tag), .wb_data(wb_data),
    .idle(idle)
  );

  // Execution unit latencies: fixed, or derived from the operands.
  bit          lat_rand    = 1'b0;
  int unsigned mul_lat_fix = 4;
  int unsigned div_lat_fix = 8;

  function automatic int unsigned lat_of(input bit is_div, input logic [W-1:0] a, b);
    if (!lat_rand) return is_div ? div_lat_fix : mul_lat_fix;
    return is_div ? ((a + b) % 10) + 1 : ((a ^ b) % 6) + 1;
  endfunction

  // Behavioural units; they do not see the dispatcher reset.
  int unsigned mul_cnt = 0, div_cnt = 0;
  always @(posedge clk) begin
    add_done <= add_valid;
    if (add_valid) add_result <= add_a + add_b;
    sub_done <= sub_valid;
    if (sub_valid) sub_result <= sub_a - sub_b;
    if (mul_valid) begin
      mul_busy   <= 1'b1;
      mul_cnt    <= lat_of(1'b0, mul_a, mul_b) - 1;
      mul_result <= mul_a * mul_b;
    end else if (mul_busy) begin
      if (mul_cnt == 0) mul_busy <= 1'b0;
      else              mul_cnt  <= mul_cnt - 1;
    end
    if (div_valid) begin
      div_busy   <= 1'b1;
      div_cnt    <= lat_of(1'b1, div_a, div_b) - 1;
      div_result <= (div_b == '0) ? '0 : div_a / div_b;
    end else if (div_busy) begin
      if (div_cnt == 0) div_busy <= 1'b0;
      else              div_cnt  <= div_cnt - 1;
    end
  end

  // Reference model state
  int               cyc;
  bit               m_live     [4];
  int               m_rdy      [4];
  logic [TAG_W-1:0] m_tag      [4];
  logic [W-1:0]     m_data     [4];
  int               busy_until [4];
  logic [W-1:0]     last_a     [4];
  logic [W-1:0]     last_b     [4];
  int               last_acc   [4];
  string            uname      [4] = '{"add", "sub", "mul", "div"};

  typedef struct {
    int               cyc;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data;
  } wb_t;
  wb_t wb_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == '0) ? '0 : a / b;
    endcase
  endfunction

  // One clock cycle: drive, check the cycle's outputs, advance the model
  // across the next edge, then move to the following negedge.
  task automatic step(input bit r, input bit v, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TAG_W-1:0] t, output bit acc);
    int           sel;
    int           e;
    int unsigned  lat;
    bit           exp_rdy;
    bit           any_live;
    logic         ov[4];
    logic [W-1:0] oa[4];
    logic [W-1:0] ob[4];
    rst = r; iss_valid = v; iss_op = op; iss_a = a; iss_b = b; iss_tag = t;
    #1;
    exp_rdy = r && !m_live[op] && (op < 2 || cyc >= busy_until[op]);
    check("iss_ready", iss_ready, exp_rdy);

    sel = -1;
    any_live = 1'b0;
    for (int u = 0; u < 4; u++) begin
      if (m_live[u]) any_live = 1'b1;
      if (r && m_live[u] && m_rdy[u] <= cyc) sel = u;
    end
    check("wb_valid", wb_valid, sel >= 0);
    if (sel >= 0) begin
      check("wb_op",   wb_op,   sel);
      check("wb_tag",  wb_tag,  m_tag[sel]);
      check("wb_data", wb_data, m_data[sel]);
    end else begin
      check("wb_op_zero",   wb_op,   0);
      check("wb_tag_zero",  wb_tag,  0);
      check("wb_data_zero", wb_data, 0);
    end
    check("idle", idle, !any_live);

    ov = '{add_valid, sub_valid, mul_valid, div_valid};
    oa = '{add_a, sub_a, mul_a, div_a};
    ob = '{add_b, sub_b, mul_b, div_b};
    for (int u = 0; u < 4; u++) begin
      check({uname[u], "_valid"}, ov[u], last_acc[u] == cyc);
      check({uname[u], "_a"}, oa[u], last_a[u]);
      check({uname[u], "_b"}, ob[u], last_b[u]);
    end

    if (wb_valid) wb_log.push_back('{cyc, wb_op, wb_tag, wb_data});

    acc = v && exp_rdy;
    if (!r) begin
      for (int u = 0; u < 4; u++) begin
        m_live[u]   = 1'b0;
        last_a[u]   = '0;
        last_b[u]   = '0;
        last_acc[u] = -1;
      end
    end else begin
      if (sel >= 0) m_live[sel] = 1'b0;
      if (acc) begin
        e            = cyc + 1;
        m_live[op]   = 1'b1;
        m_tag[op]    = t;
        m_data[op]   = ref_result(op, a, b);
        last_acc[op] = e;
        last_a[op]   = a;
        last_b[op]   = b;
        if (op < 2) begin
          m_rdy[op] = e + 2;
        end else begin
          lat            = lat_of(op == 2'd3, a, b);
          m_rdy[op]      = e + 2 + int'(lat);
          busy_until[op] = e + 1 + int'(lat);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'(cyc % 4), '0, '0, '0, acc);
  endtask

  task automatic issue_until(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [TAG_W-1:0] t, output int edge_no);
    bit acc = 1'b0;
    edge_no = -1;
    for (int i = 0; i < 64 && !acc; i++) begin
      step(1'b1, 1'b1, op, a, b, t, acc);
      if (acc) edge_no = cyc;
    end
    if (!acc) check("issue_timeout", acc, 1'b1);
  endtask

  function automatic int count_wb(input logic [TAG_W-1:0] t, input int from);
    int n = 0;
    foreach (wb_log[i]) if (wb_log[i].cyc >= from && wb_log[i].tag == t) n++;
    return n;
  endfunction

  task automatic expect_wb(input string name, input logic [TAG_W-1:0] t, input int from,
                           input int exp_at, input logic [1:0] exp_op, input logic [W-1:0] exp_d);
    int           at = -1;
    logic [1:0]   o  = '0;
    logic [W-1:0] d  = '0;
    foreach (wb_log[i]) begin
      if (wb_log[i].cyc >= from && wb_log[i].tag == t) begin
        at = wb_log[i].cyc;
        o  = wb_log[i].op;
        d  = wb_log[i].data;
      end
    end
    check({name, "_count"}, count_wb(t, from), 1);
    check({name, "_cycle"}, at, exp_at);
    check({name, "_op"},    o,  exp_op);
    check({name, "_data"},  d,  exp_d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit           acc;
    int           e, e2;
    logic [W-1:0] exp_wrap;
    logic [W-1:0] ra, rb;

    cyc = 0;
    for (int u = 0; u < 4; u++) begin
      m_live[u] = 1'b0; m_rdy[u] = 0; m_tag[u] = '0; m_data[u] = '0;
      busy_until[u] = 0; last_a[u] = '0; last_b[u] = '0; last_acc[u] = -1;
    end
    rst = 1'b0; iss_valid = 1'b0; iss_op = '0; iss_a = '0; iss_b = '0; iss_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held: ready low, no writeback, idle
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 32'd1, 32'd1, 4'd1, acc);
    idle_cycles(3);

    // ADD 5+7 tag 3
    step(1'b1, 1'b1, 2'd0, 32'd5, 32'd7, 4'd3, acc);
    check("add_accept", acc, 1'b1);
    e = cyc;
    idle_cycles(5);
    expect_wb("add_5_7", 4'd3, e, e + 2, 2'd0, 32'd12);

    // MUL 6x7 tag 1, then ADD 1+1 tag 2; probe MUL readiness meanwhile
    step(1'b1, 1'b1, 2'd2, 32'd6, 32'd7, 4'd1, acc);
    check("mul_accept", acc, 1'b1);
    e = cyc;
    step(1'b1, 1'b1, 2'd0, 32'd1, 32'd1, 4'd2, acc);
    check("add_after_mul_accept", acc, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 2'd2, '0, '0, '0, acc);
    idle_cycles(2);
    expect_wb("add_1_1", 4'd2, e, e + 3, 2'd0, 32'd2);
    expect_wb("mul_6_7", 4'd1, e, e + 6, 2'd2, 32'd42);

    // DIV by zero tag 5
    step(1'b1, 1'b1, 2'd3, 32'd100, 32'd0, 4'd5, acc);
    check("div0_accept", acc, 1'b1);
    e = cyc;
    idle_cycles(12);
    expect_wb("div_by_0", 4'd5, e, e + 10, 2'd3, 32'd0);

    // DIV, MUL, SUB all captured on the same edge
    mul_lat_fix = 8;
    div_lat_fix = 4;
    step(1'b1, 1'b1, 2'd2, 32'd3, 32'd5, 4'd6, acc);
    check("coll_mul_accept", acc, 1'b1);
    e = cyc;
    idle_cycles(3);
    step(1'b1, 1'b1, 2'd3, 32'd20, 32'd4, 4'd7, acc);
    check("coll_div_accept", acc, 1'b1);
    check("coll_div_edge", cyc, e + 4);
    idle_cycles(3);
    step(1'b1, 1'b1, 2'd1, 32'd9, 32'd4, 4'd8, acc);
    check("coll_sub_accept", acc, 1'b1);
    check("coll_sub_edge", cyc, e + 8);
    idle_cycles(8);
    expect_wb("coll_div", 4'd7, e, e + 10, 2'd3, 32'd5);
    expect_wb("coll_mul", 4'd6, e, e + 11, 2'd2, 32'd15);
    expect_wb("coll_sub", 4'd8, e, e + 12, 2'd1, 32'd5);
    mul_lat_fix = 4;
    div_lat_fix = 8;

    // DIV discarded by reset; next DIV waits for the unit to drain
    step(1'b1, 1'b1, 2'd3, 32'd50, 32'd7, 4'd9, acc);
    check("rst_div_accept", acc, 1'b1);
    e = cyc;
    idle_cycles(2);
    step(1'b0, 1'b0, 2'd3, '0, '0, '0, acc);
    issue_until(2'd3, 32'd9, 32'd3, 4'd10, e2);
    check("div_after_rst_edge", e2, e + 10);
    idle_cycles(12);
    check("rst_div_dropped", count_wb(4'd9, e), 0);
    expect_wb("div_9_3", 4'd10, e2, e2 + 10, 2'd3, 32'd3);

    // SUB wrap-around, then a second SUB held until the slot clears
    exp_wrap = '1;
    exp_wrap = exp_wrap - 1;
    issue_until(2'd1, 32'd3, 32'd5, 4'd11, e);
    issue_until(2'd1, 32'd10, 32'd3, 4'd12, e2);
    check("sub_hold_edge", e2, e + 4);
    idle_cycles(4);
    expect_wb("sub_wrap", 4'd11, e, e + 2, 2'd1, exp_wrap);
    expect_wb("sub_second", 4'd12, e2, e2 + 2, 2'd1, 32'd7);

    // Random traffic with operand-dependent latencies and sporadic reset
    lat_rand = 1'b1;
    for (int i = 0; i < 700; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      step($urandom_range(0, 59) != 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ra, rb, TAG_W'($urandom), acc);
    end
    idle_cycles(24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
